ifetch_queue: RTL
=================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries and maximum outstanding memory requests; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00400000, meaning first fetch address after reset.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port mem_req_valid  output  1  fetch request to instruction memory.
REQ-006 Port mem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 Port mem_req_addr  output  32  word-aligned fetch address.
REQ-008 Port mem_rsp_valid  input  1  response word valid; responses return in request order, no backpressure.
REQ-009 Port mem_rsp_data  input  32  instruction word.
REQ-010 Port redirect_valid  input  1  pipeline redirect (taken branch, JAL, JALR).
REQ-011 Port redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-012 Port out_valid  output  1  head entry holds a fetched instruction.
REQ-013 Port out_ready  input  1  decode stage accepts the head entry.
REQ-014 Port out_pc  output  32  PC of head entry.
REQ-015 Port out_ir  output  32  instruction word of head entry.

Function
REQ-016 Request handshake: a request transfers when mem_req_valid & mem_req_ready; fetch_pc advances by 4 per transfer.
REQ-017 mem_req_valid is high exactly when (reserved entries + dropped-in-flight count) < DEPTH; mem_req_addr equals fetch_pc.
REQ-018 Issue reserves a ring entry at the tail, storing the PC, with its filled bit clear.
REQ-019 Response while drop_cnt > 0: discarded; drop_cnt decrements. Otherwise: writes mem_rsp_data into the oldest unfilled reserved entry and sets its filled bit.
REQ-020 out_valid is high exactly when the head entry is reserved and filled; out_pc and out_ir come from registers, with no combinational path from mem_rsp_*.
REQ-021 Latency: a response accepted in cycle N into the head entry gives out_valid in cycle N+1.
REQ-022 Pop: out_valid & out_ready frees the head in the same edge; issue into the freed slot is allowed from the next cycle.
REQ-023 Redirect in cycle N: the out transfer of cycle N, if any, completes. All remaining entries are freed. drop_cnt becomes (old drop_cnt + unfilled reserved entries + request transferred in cycle N − response consumed in cycle N). fetch_pc becomes {redirect_pc[31:2],2'b00}. out_valid is low in cycle N+1.
REQ-024 Redirect may withdraw an unaccepted request; in cycle N+1, mem_req_addr carries the new PC if capacity allows.
REQ-025 Redirect while drop_cnt > 0 accumulates into drop_cnt; drop_cnt never exceeds DEPTH.
REQ-026 Full: DEPTH reserved entries hold mem_req_valid low; the queue resumes on pop. Empty: out_valid is low.
REQ-027 Ring head and tail pointers wrap modulo DEPTH; full and empty are distinguished by an occupancy counter of log2(DEPTH)+1 bits.
REQ-028 A response arriving with no reserved unfilled entry and drop_cnt = 0 is a protocol error; it is ignored, with a simulation assertion.

Reset
REQ-029 While rst is low: mem_req_valid=0, out_valid=0, mem_req_addr=RESET_PC, out_pc=0, out_ir=0, all entries free, drop_cnt=0, fetch_pc=RESET_PC.
REQ-030 Reset asserted mid-operation clears state immediately; responses to requests in flight at reset are the memory's responsibility and are not dropped.
REQ-031 First cycle after rst rises: mem_req_valid=1 with address RESET_PC.

Structure
REQ-032 Shared package ifq_pkg holds RESET_PC default, the instruction-word width, and the entry record {pc, ir, filled}.
REQ-033 One sub-module ifq_ring (DEPTH-entry storage plus head/tail/fill pointers); counters and redirect logic live in ifetch_queue.

Verification
REQ-034 Reset release, memory ready with 1-cycle latency, out_ready=1 -> out_pc sequence 0x00400000, 0x00400004, 0x00400008, one per cycle after fill.
REQ-035 out_ready=0, DEPTH=4 -> exactly 4 requests issued (0x00400000..0x0040000C), then mem_req_valid low until a pop.
REQ-036 3 requests outstanding, redirect to 0x00400043 -> next mem_req_addr=0x00400040; next 3 responses discarded; first out_pc=0x00400040.
REQ-037 Redirect in same cycle as out handshake and mem_rsp_valid -> popped entry counted consumed; response counted as dropped; no stale out_valid.
REQ-038 Two redirects 2 cycles apart while draining -> drop_cnt sums correctly, never exceeds 4; only second target's stream appears.
REQ-039 rst pulled low mid-stream for 1 cycle -> all outputs at reset values asynchronously; fetch restarts at 0x00400000.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam logic [AW-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // One queue slot: fetch address, returned word, and whether the word has arrived.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic          filled;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ring.sv
// DEPTH-entry fetch ring: head (oldest), tail (next to reserve), fill (oldest unfilled).
// Also exposes a look-ahead of the head entry so the parent can register its outputs.
module ifq_ring
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_pc,
  input  logic                   fill,
  input  logic [IW-1:0]          fill_ir,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] unfilled,
  output logic [$clog2(DEPTH):0] count_nxt_c,
  output ifq_entry_t             head_nxt_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ifq_entry_t    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ufc_q, ufc_d;

  // Pointer and occupancy update; a flush frees every entry.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    ufc_d  = ufc_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      ufc_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (fill) fill_d = fill_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      ufc_d = ufc_q + CW'(push) - CW'(fill);
    end
  end

  // Contents of the slot that will be at the head after this edge.
  always_comb begin
    head_nxt_c = mem_q[head_d];
    if (!flush && push && (tail_q == head_d)) begin
      head_nxt_c.pc     = push_pc;
      head_nxt_c.filled = 1'b0;
    end
    if (!flush && fill && (fill_q == head_d)) begin
      head_nxt_c.ir     = fill_ir;
      head_nxt_c.filled = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      ufc_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      ufc_q  <= ufc_d;
    end
  end

  // Responses arrive in order, so the fill pointer always names the slot to write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush) begin
      if (push) begin
        mem_q[tail_q].pc     <= push_pc;
        mem_q[tail_q].filled <= 1'b0;
      end
      if (fill) begin
        mem_q[fill_q].ir     <= fill_ir;
        mem_q[fill_q].filled <= 1'b1;
      end
    end
  end

  assign unfilled    = ufc_q;
  assign count_nxt_c = cnt_d;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order responses,
// and on a redirect discards everything already asked for but not yet delivered.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [IW-1:0] mem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [IW-1:0] out_ir
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_pc_q, out_pc_d;
  logic [IW-1:0] out_ir_q, out_ir_d;

  logic          req_xfer;
  logic          pop;
  logic          rsp_drop;
  logic          rsp_fill;
  logic [CW-1:0] ring_unfilled;
  logic [CW-1:0] ring_count_nxt;
  ifq_entry_t    head_nxt;
  logic          unused_ok_c;

  assign unused_ok_c = ^redirect_pc[1:0];

  // Handshake decode, drop accounting, fetch address and registered outputs.
  always_comb begin
    req_xfer        = mem_req_valid_q & mem_req_ready;
    pop             = out_valid_q & out_ready;
    rsp_drop        = mem_rsp_valid & (drop_q != '0);
    rsp_fill        = mem_rsp_valid & (drop_q == '0) & (ring_unfilled != '0);
    fetch_pc_d      = fetch_pc_q;
    drop_d          = drop_q;
    if (redirect_valid) begin
      // Everything in flight or just issued becomes garbage, minus this cycle's response.
      fetch_pc_d = {redirect_pc[AW-1:2], 2'b00};
      drop_d     = drop_q + ring_unfilled + CW'(req_xfer) - CW'(rsp_drop | rsp_fill);
    end else begin
      if (req_xfer) fetch_pc_d = fetch_pc_q + AW'(4);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end
    mem_req_valid_d = (SW'(ring_count_nxt) + SW'(drop_d)) < SW'(DEPTH);
    out_valid_d     = (ring_count_nxt != '0) & head_nxt.filled;
    out_pc_d        = out_valid_d ? head_nxt.pc : out_pc_q;
    out_ir_d        = out_valid_d ? head_nxt.ir : out_ir_q;
  end

  ifq_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .push        (req_xfer & ~redirect_valid),
    .push_pc     (fetch_pc_q),
    .fill        (rsp_fill & ~redirect_valid),
    .fill_ir     (mem_rsp_data),
    .pop         (pop),
    .flush       (redirect_valid),
    .unfilled    (ring_unfilled),
    .count_nxt_c (ring_count_nxt),
    .head_nxt_c  (head_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q      <= RESET_PC;
      drop_q          <= '0;
      mem_req_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_pc_q        <= '0;
      out_ir_q        <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      drop_q          <= drop_d;
      mem_req_valid_q <= mem_req_valid_d;
      out_valid_q     <= out_valid_d;
      out_pc_q        <= out_pc_d;
      out_ir_q        <= out_ir_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_ir        = out_ir_q;

  // A response is only legal if something is waiting for it or due to be thrown away.
  property p_rsp_expected;
    @(posedge clk) disable iff (!rst)
      mem_rsp_valid |-> ((drop_q != '0) || (ring_unfilled != '0));
  endproperty
  a_rsp_expected: assert property (p_rsp_expected)
    else $error("ifetch_queue: response with nothing outstanding");

endmodule
